// File: rtl/cnn_window_conv.sv
// cnn_window_conv: collects a serial 3x3 binary window, scores it against a binary
// kernel, and packs the thresholded result bits LSB first into bytes for the UART.
`default_nettype none

module cnn_window_conv #(
  parameter int N_WIN = 676,
  parameter int KW    = 9
) (
  input  logic          clk,
  input  logic          rst_n1,
  input  logic          strt,
  input  logic          din,
  input  logic [KW-1:0] kernel,
  input  logic [3:0]    thr,
  output logic          bsy,
  output logic [7:0]    dout,
  output logic          trmt,
  input  logic          tx_done,
  output logic          frame_done
);

  localparam logic [9:0] N_WIN_C  = 10'(N_WIN);
  localparam logic [3:0] LAST_BIT = 4'(KW - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACC     = 3'd1,
    EVAL    = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [KW-1:0] window;
  logic [3:0]    bit_cnt;
  logic [3:0]    pack_cnt;
  logic [9:0]    win_cnt;
  logic [7:0]    pack;
  logic [7:0]    dout_q;
  logic          frame_done_q;
  logic [3:0]    match;
  logic          result;

  // XNOR popcount: number of window bits agreeing with their kernel weight
  always_comb begin
    match = '0;
    for (int i = 0; i < KW; i++) begin
      match = match + {3'b000, ~(window[i] ^ kernel[i])};
    end
    result = (match >= thr);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (strt) state_nxt = ACC;
      ACC:     if (bit_cnt == LAST_BIT) state_nxt = EVAL;
      EVAL: begin
        if ((pack_cnt == 4'd7) || (win_cnt == N_WIN_C - 10'd1)) state_nxt = SEND;
        else                                                   state_nxt = IDLE;
      end
      SEND:    state_nxt = WAIT_TX;
      WAIT_TX: if (tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n1) begin
    if (!rst_n1) begin
      state        <= IDLE;
      window       <= '0;
      bit_cnt      <= '0;
      pack_cnt     <= '0;
      win_cnt      <= '0;
      pack         <= '0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (strt) bit_cnt <= '0;
        end
        ACC: begin
          window[bit_cnt] <= din;
          bit_cnt         <= bit_cnt + 4'd1;
        end
        EVAL: begin
          pack[pack_cnt[2:0]] <= result;
          pack_cnt            <= pack_cnt + 4'd1;
          win_cnt             <= win_cnt + 10'd1;
        end
        SEND: begin
          dout_q   <= pack;
          pack     <= '0;
          pack_cnt <= '0;
        end
        WAIT_TX: begin
          // frame wraps only once its final byte has been acknowledged
          if (tx_done && (win_cnt == N_WIN_C)) begin
            frame_done_q <= 1'b1;
            win_cnt      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // dout shows the fresh byte during SEND and then holds it until the next SEND
  assign dout       = (state == SEND) ? pack : dout_q;
  assign trmt       = (state == SEND);
  assign bsy        = (state != IDLE);
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire
